// File: rtl/sti_pkg.sv
// Shared types for the STI command scheduler: command layout, length codes,
// scheduler states and the length-to-bit-count helper.
package sti_pkg;

  localparam int CMD_W        = 22;
  localparam int CMD_END_BIT  = 21;
  localparam int CMD_FILL_BIT = 20;
  localparam int CMD_MSB_BIT  = 19;
  localparam int CMD_LOW_BIT  = 18;
  localparam int CMD_LEN_LSB  = 16;
  localparam int CMD_DATA_LSB = 0;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2,
    LEN32 = 2'd3
  } sti_len_e;

  // fin is the end-of-stream flag (top bit of the command word)
  typedef struct packed {
    logic        fin;
    logic        fill;
    logic        msb;
    logic        low;
    sti_len_e    length;
    logic [15:0] data;
  } sti_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_SO,
    ST_SHIFT,
    ST_DRAIN,
    ST_FIN_WAIT,
    ST_HALT
  } sti_state_e;

  function automatic logic [5:0] bits_for_len(input sti_len_e len);
    return (6'(len) + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/sti_sched_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester that did not win last.
module rr_arb2 import sti_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;
  logic pick;

  always_comb begin
    pick = 1'b0;
    if (req_i == 2'b10)      pick = 1'b1;
    else if (req_i == 2'b11) pick = ~last_q;
  end

  assign gnt_id_o = pick;
  assign gnt_o    = (en_i && (|req_i)) ? (pick ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    last_d = last_q;
    if (en_i && (|req_i)) last_d = pick;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/sti_sched.sv
// Arbitrates two command requesters onto the STI serializer, one transfer at a
// time, tracking completion by counting so_valid cycles.
module sti_sched import sti_pkg::*; #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [21:0] req0_cmd,
  input  logic [21:0] req1_cmd,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  input  logic        pixel_finish,
  output logic        busy,
  output logic        grant_id,
  output logic        cmd_done,
  output logic        timeout_err,
  output logic        all_done
);

  sti_state_e state_q, state_d;
  logic [6:0] wcnt_q, wcnt_d;
  logic [5:0] bcnt_q, bcnt_d;
  sti_cmd_t   cmd_q, cmd_d, cmd_in;
  logic       pi_end_q, pi_end_d;
  logic       grant_q, grant_d;
  logic       cmd_done_q, cmd_done_d;
  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == ST_IDLE),
    .req_i    (req_valid),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign cmd_in = gnt_id ? req1_cmd : req0_cmd;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    cmd_d       = cmd_q;
    pi_end_d    = pi_end_q;
    grant_d     = grant_q;
    cmd_done_d  = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          cmd_d    = cmd_in;
          pi_end_d = cmd_in.fin;
          grant_d  = gnt_id;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wcnt_d  = 7'd0;
        bcnt_d  = 6'd0;
        state_d = ST_WAIT_SO;
      end
      // timeout wins over a so_valid arriving on the very last allowed cycle
      ST_WAIT_SO: begin
        if (wcnt_q == 7'(TIMEOUT)) begin
          timeout_err = 1'b1;
          pi_end_d    = 1'b0;
          state_d     = ST_IDLE;
        end else if (so_valid) begin
          bcnt_d  = 6'd1;
          state_d = ST_SHIFT;
        end else begin
          wcnt_d = wcnt_q + 7'd1;
        end
      end
      ST_SHIFT: begin
        if (bcnt_q == bits_for_len(cmd_q.length)) state_d = ST_DRAIN;
        else if (so_valid)                        bcnt_d  = bcnt_q + 6'd1;
      end
      ST_DRAIN: begin
        if (!so_valid) begin
          cmd_done_d = 1'b1;
          state_d    = cmd_q.fin ? ST_FIN_WAIT : ST_IDLE;
        end
      end
      ST_FIN_WAIT: begin
        if (pixel_finish) state_d = ST_HALT;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 7'd0;
      bcnt_q     <= 6'd0;
      cmd_q      <= '0;
      pi_end_q   <= 1'b0;
      grant_q    <= 1'b0;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      cmd_q      <= cmd_d;
      pi_end_q   <= pi_end_d;
      grant_q    <= grant_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  assign req_ready = gnt;
  assign load      = (state_q == ST_LOAD);
  assign pi_data   = cmd_q.data;
  assign pi_length = cmd_q.length;
  assign pi_fill   = cmd_q.fill;
  assign pi_msb    = cmd_q.msb;
  assign pi_low    = cmd_q.low;
  assign pi_end    = pi_end_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign grant_id  = grant_q;
  assign cmd_done  = cmd_done_q;
  assign all_done  = (state_q == ST_HALT);

endmodule

// File: tb/tb_sti_sched.sv
// Directed bench for sti_sched: arbitration, transfer timing, timeout, halt and reset.
module tb_sti_sched;
  import sti_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [21:0] req0_cmd, req1_cmd;
  logic        load, pi_fill, pi_msb, pi_low, pi_end;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        so_valid, pixel_finish;
  logic        busy, grant_id, cmd_done, timeout_err, all_done;

  sti_sched #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .pixel_finish(pixel_finish),
    .busy(busy), .grant_id(grant_id), .cmd_done(cmd_done),
    .timeout_err(timeout_err), .all_done(all_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] outs();
    return {load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
            req_ready, busy, grant_id, cmd_done, timeout_err, all_done};
  endfunction

  function automatic logic [21:0] mk(input logic fin, input logic fill, input logic msb,
                                     input logic low, input sti_len_e len, input logic [15:0] d);
    sti_cmd_t c;
    c.fin = fin; c.fill = fill; c.msb = msb; c.low = low; c.length = len; c.data = d;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = load, 1 = cmd_done, 2 = timeout_err; returns cycle number seen
  task automatic wait_sig(input string tag, input int sel, output int at);
    bit seen = 1'b0;
    logic s;
    at = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      s = (sel == 0) ? load : (sel == 1) ? cmd_done : timeout_err;
      if (s) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  // so_valid pattern starting in the first WAIT_SO cycle; gapped drops every 4th cycle
  task automatic drive_bits(input int nhigh, input bit gapped);
    int h = 0;
    int k = 0;
    while (h < nhigh) begin
      if (gapped && (k % 4) == 3) so_valid = 1'b0;
      else begin
        so_valid = 1'b1;
        h++;
      end
      k++;
      tick();
    end
    so_valid = 1'b0;
  endtask

  int t_load, t_done, t_tmo;
  logic exp_g;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; req0_cmd = '0; req1_cmd = '0;
    so_valid = 1'b0; pixel_finish = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(outs()), 32'd0);
    tick();
    reset = 1'b0;

    // single req0, 8-bit
    req0_cmd  = mk(1'b0, 1'b0, 1'b0, 1'b0, LEN8, 16'h00A5);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_load_pre", 32'(load), 32'd0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    t_load = cyc;
    chk("t1_load", 32'(load), 32'd1);
    chk("t1_data", 32'(pi_data), 32'h00A5);
    chk("t1_gid", 32'(grant_id), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    drive_bits(8, 1'b0);
    wait_sig("t1_done", 1, t_done);
    chk("t1_lat", 32'(t_done - t_load), 32'd11);
    tick();
    @(negedge clk);
    chk("t1_done_once", 32'(cmd_done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_hold", 32'(pi_data), 32'h00A5);

    // both requesters continuously valid; last winner was req0 so req1 leads
    tick();
    req0_cmd  = mk(1'b0, 1'b1, 1'b1, 1'b0, LEN16, 16'h1111);
    req1_cmd  = mk(1'b0, 1'b0, 1'b0, 1'b1, LEN16, 16'h2222);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t2_ready_first", 32'(req_ready), 32'h2);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0);
      wait_sig($sformatf("t2_%0d_load", k), 0, t_load);
      chk($sformatf("t2_%0d_gid", k), 32'(grant_id), 32'(exp_g));
      chk($sformatf("t2_%0d_data", k), 32'(pi_data), exp_g ? 32'h2222 : 32'h1111);
      chk($sformatf("t2_%0d_mode", k), 32'({pi_fill, pi_msb, pi_low}), exp_g ? 32'h1 : 32'h6);
      chk($sformatf("t2_%0d_len", k), 32'(pi_length), 32'd1);
      tick();
      drive_bits(16, 1'b0);
      wait_sig($sformatf("t2_%0d_done", k), 1, t_done);
      chk($sformatf("t2_%0d_lat", k), 32'(t_done - t_load), 32'd19);
      if (k == 3) req_valid = 2'b00;
      else chk($sformatf("t2_%0d_next", k), 32'(req_ready), exp_g ? 32'h1 : 32'h2);
    end

    // gapped 32-bit from req1 alone, so_valid lingers 3 cycles, pixel_finish ignored
    tick();
    req1_cmd     = mk(1'b0, 1'b0, 1'b1, 1'b0, LEN32, 16'hBEEF);
    req_valid    = 2'b10;
    pixel_finish = 1'b1;
    @(negedge clk);
    chk("t3_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    t_load = cyc;
    chk("t3_load", 32'(load), 32'd1);
    chk("t3_gid", 32'(grant_id), 32'd1);
    chk("t3_len", 32'(pi_length), 32'd3);
    tick();
    drive_bits(32, 1'b1);
    so_valid = 1'b1;
    repeat (3) tick();
    so_valid = 1'b0;
    wait_sig("t3_done", 1, t_done);
    chk("t3_lat", 32'(t_done - t_load), 32'd47);
    tick();
    pixel_finish = 1'b0;
    @(negedge clk);
    chk("t3_no_halt", 32'(all_done), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // timeout with an end-flagged command: aborts to IDLE, pi_end cleared
    tick();
    req0_cmd  = mk(1'b1, 1'b0, 1'b0, 1'b0, LEN8, 16'h0F0F);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    t_load = cyc;
    chk("t4_load", 32'(load), 32'd1);
    chk("t4_pi_end", 32'(pi_end), 32'd1);
    wait_sig("t4_tmo", 2, t_tmo);
    chk("t4_lat", 32'(t_tmo - t_load), 32'd65);
    tick();
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_tmo_pulse", 32'(timeout_err), 32'd0);
    chk("t4_pi_end_clr", 32'(pi_end), 32'd0);
    chk("t4_no_halt", 32'(all_done), 32'd0);

    // end-flagged command, pixel_finish 10 cycles after the drain
    tick();
    req0_cmd  = mk(1'b1, 1'b0, 1'b0, 1'b0, LEN8, 16'h5A5A);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    t_load = cyc;
    chk("t5_load", 32'(load), 32'd1);
    chk("t5_pi_end", 32'(pi_end), 32'd1);
    tick();
    drive_bits(8, 1'b0);
    wait_sig("t5_done", 1, t_done);
    chk("t5_lat", 32'(t_done - t_load), 32'd11);
    chk("t5_pi_end_done", 32'(pi_end), 32'd1);
    repeat (10) tick();
    pixel_finish = 1'b1;
    @(negedge clk);
    chk("t5_finwait_busy", 32'(busy), 32'd1);
    chk("t5_finwait_all", 32'(all_done), 32'd0);
    tick();
    pixel_finish = 1'b0;
    @(negedge clk);
    chk("t5_all_done", 32'(all_done), 32'd1);
    chk("t5_halt_busy", 32'(busy), 32'd0);
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    chk("t5_halt_ready", 32'(req_ready), 32'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("t5_halt_load", 32'(load), 32'd0);
    chk("t5_halt_sticky", 32'(all_done), 32'd1);
    req_valid = 2'b00;

    // reset out of HALT, then reset in the middle of a req0 transfer
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_halt_rst", 32'(outs()), 32'd0);
    tick();
    reset     = 1'b0;
    req0_cmd  = mk(1'b0, 1'b1, 1'b0, 1'b1, LEN24, 16'hC3C3);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t6_load", 32'(load), 32'd1);
    tick();
    so_valid = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("t6_shift_busy", 32'(busy), 32'd1);
    chk("t6_shift_data", 32'(pi_data), 32'hC3C3);
    tick();
    reset    = 1'b1;
    so_valid = 1'b0;
    @(negedge clk);
    chk("t6_mid_rst", 32'(outs()), 32'd0);
    tick();
    reset     = 1'b0;
    req0_cmd  = mk(1'b0, 1'b0, 1'b0, 1'b0, LEN8, 16'h0077);
    req1_cmd  = mk(1'b0, 1'b0, 1'b0, 1'b0, LEN8, 16'h0088);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    t_load = cyc;
    chk("t6_reload", 32'(load), 32'd1);
    chk("t6_gid", 32'(grant_id), 32'd0);
    chk("t6_data", 32'(pi_data), 32'h0077);
    tick();
    drive_bits(8, 1'b0);
    wait_sig("t6_done", 1, t_done);
    chk("t6_lat", 32'(t_done - t_load), 32'd11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
